sseg_scan_ctrl: RTL and testbench

SSEG_SCAN_CTRL -- requirements
Module: sseg_scan_ctrl

---
 rtl/sseg_scan_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_sseg_scan_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_ctrl.sv
// Multiplexed seven-segment scan controller with a debounced freeze button.
// Optional leading-zero blanking is compiled in with `define SSEG_LEAD_BLANK_EN.
module sseg_scan_ctrl #(
    parameter int NUM_DIGITS      = 4,
    parameter int REFRESH_DIV     = 50000,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    but0,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              sseg,
    output logic                    dp,
    output logic                    frozen
);

    localparam int IW = $clog2(NUM_DIGITS);
    localparam int RW = $clog2(REFRESH_DIV);
    localparam int SW = $clog2(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } db_state_t;

    logic [RW-1:0]           refr_q, refr_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    scan_en_q, scan_en_d;
    logic [1:0]              sync_q, sync_d;
    db_state_t               st_q, st_d;
    logic [SW-1:0]           stab_q, stab_d;
    logic                    frozen_q, frozen_d;
    logic [4*NUM_DIGITS-1:0] hold_val_q, hold_val_d;
    logic [NUM_DIGITS-1:0]   hold_dp_q, hold_dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [6:0]              sseg_q, sseg_d;
    logic                    dp_q, dp_d;

    logic                    btn;
    logic                    toggle;
    logic [4*NUM_DIGITS-1:0] src_val;
    logic [NUM_DIGITS-1:0]   src_dp;
    logic [3:0]              nib;

    function automatic logic [6:0] hex7(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Refresh divider and digit index; index holds at 0 until the first slot opens
    always_comb begin
        refr_d    = refr_q + 1'b1;
        idx_d     = idx_q;
        scan_en_d = scan_en_q;
        if (refr_q == RW'(REFRESH_DIV - 1)) begin
            refr_d    = '0;
            scan_en_d = 1'b1;
            if (scan_en_q) begin
                if (idx_q == IW'(NUM_DIGITS - 1)) idx_d = '0;
                else                              idx_d = idx_q + 1'b1;
            end
        end
    end

    assign sync_d = {sync_q[0], but0};
    assign btn    = sync_q[1];

    // Debounce FSM: one toggle pulse per accepted press
    always_comb begin
        st_d   = st_q;
        stab_d = stab_q;
        toggle = 1'b0;
        unique case (st_q)
            IDLE: begin
                if (btn) begin
                    st_d   = PRESS_WAIT;
                    stab_d = '0;
                end
            end
            PRESS_WAIT: begin
                if (!btn) begin
                    st_d = IDLE;
                end else if (stab_q == SW'(DEBOUNCE_CYCLES - 1)) begin
                    st_d   = HELD;
                    toggle = 1'b1;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            HELD: begin
                if (!btn) begin
                    st_d   = RELEASE_WAIT;
                    stab_d = '0;
                end
            end
            RELEASE_WAIT: begin
                if (btn) begin
                    st_d = HELD;
                end else if (stab_q == SW'(DEBOUNCE_CYCLES - 1)) begin
                    st_d = IDLE;
                end else begin
                    stab_d = stab_q + 1'b1;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // Freeze flag and snapshot of the inputs taken as the display freezes
    always_comb begin
        frozen_d   = frozen_q ^ toggle;
        hold_val_d = hold_val_q;
        hold_dp_d  = hold_dp_q;
        if (toggle && !frozen_q) begin
            hold_val_d = value;
            hold_dp_d  = dp_in;
        end
    end

    assign src_val = frozen_q ? hold_val_q : value;
    assign src_dp  = frozen_q ? hold_dp_q  : dp_in;
    assign nib     = src_val[4*idx_q +: 4];

    // Output decode for the current digit, registered into an/sseg/dp
    always_comb begin
`ifdef SSEG_LEAD_BLANK_EN
        logic [IW-1:0] msnz;
        msnz = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (src_val[4*i +: 4] != 4'h0) msnz = IW'(i);
        end
`endif
        an_d   = '1;
        sseg_d = 7'h7F;
        dp_d   = 1'b1;
        if (scan_en_q) begin
            an_d[idx_q] = 1'b0;
            sseg_d      = hex7(nib);
            dp_d        = ~src_dp[idx_q];
`ifdef SSEG_LEAD_BLANK_EN
            if (idx_q > msnz) sseg_d = 7'h7F;
`endif
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refr_q     <= '0;
            idx_q      <= '0;
            scan_en_q  <= 1'b0;
            sync_q     <= '0;
            st_q       <= IDLE;
            stab_q     <= '0;
            frozen_q   <= 1'b0;
            hold_val_q <= '0;
            hold_dp_q  <= '0;
            an_q       <= '1;
            sseg_q     <= 7'h7F;
            dp_q       <= 1'b1;
        end else begin
            refr_q     <= refr_d;
            idx_q      <= idx_d;
            scan_en_q  <= scan_en_d;
            sync_q     <= sync_d;
            st_q       <= st_d;
            stab_q     <= stab_d;
            frozen_q   <= frozen_d;
            hold_val_q <= hold_val_d;
            hold_dp_q  <= hold_dp_d;
            an_q       <= an_d;
            sseg_q     <= sseg_d;
            dp_q       <= dp_d;
        end
    end

    assign an     = an_q;
    assign sseg   = sseg_q;
    assign dp     = dp_q;
    assign frozen = frozen_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Self-checking bench for sseg_scan_ctrl (4 digits, refresh 4, debounce 8).
// Define SSEG_LEAD_BLANK_EN to check the blanking build.
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        but0 = 1'b0;
    logic [15:0] value = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;
    logic        frozen;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] sseg;
        logic       dp;
    } slot_t;

    slot_t sb[$];
    int    n_run = 0;
    int    n_fail = 0;
    int    cyc;

    sseg_scan_ctrl #(
        .NUM_DIGITS(4),
        .REFRESH_DIV(4),
        .DEBOUNCE_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .but0(but0),
        .value(value),
        .dp_in(dp_in),
        .an(an),
        .sseg(sseg),
        .dp(dp),
        .frozen(frozen)
    );

    always #5 clk = ~clk;

    // clock edges since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    function automatic logic [6:0] exp_seg(input logic [15:0] v, input int idx);
        logic [3:0] n;
        logic [6:0] s;
        n = v[idx*4 +: 4];
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
`ifdef SSEG_LEAD_BLANK_EN
        begin
            int top;
            top = 0;
            for (int i = 1; i < 4; i++) if (v[i*4 +: 4] != 4'h0) top = i;
            if (idx > top) s = 7'h7F;
        end
`endif
        return s;
    endfunction

    // first slot visible at edge 5, then one every 4 edges
    task automatic push_slots(input int n, input logic [15:0] v, input logic [3:0] d);
        int c0;
        int idx;
        slot_t e;
        c0  = (cyc < 5) ? 5 : cyc + 4 - ((cyc - 5) % 4);
        idx = ((c0 - 5) / 4) % 4;
        for (int k = 0; k < n; k++) begin
            e.an       = 4'hF;
            e.an[idx]  = 1'b0;
            e.sseg     = exp_seg(v, idx);
            e.dp       = ~d[idx];
            sb.push_back(e);
            idx = (idx + 1) % 4;
        end
    endtask

    task automatic next_slot(output slot_t o, output int c, output bit ok);
        logic [3:0] last;
        last = an;
        ok   = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (an !== last) ok = 1'b1;
        end
        o = {an, sseg, dp};
        c = cyc;
    endtask

    task automatic test_reset();
        slot_t o, e;
        int c;
        bit ok;
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        n_run++;
        if (an !== 4'hF) begin
            n_fail++; $display("FAIL reset_an got %b want 1111", an);
        end
        n_run++;
        if (sseg !== 7'h7F) begin
            n_fail++; $display("FAIL reset_sseg got %h want 7f", sseg);
        end
        n_run++;
        if (dp !== 1'b1 || frozen !== 1'b0) begin
            n_fail++; $display("FAIL reset_dp_frozen got %b%b want 10", dp, frozen);
        end
        value = 16'h1234;
        dp_in = 4'h0;
        rst   = 1'b0;
        push_slots(8, value, dp_in);
        for (int k = 0; k < 8; k++) begin
            next_slot(o, c, ok);
            e = sb.pop_front();
            n_run++;
            if (!ok || o !== e) begin
                n_fail++;
                $display("FAIL reset_scan%0d got %b/%h/%b want %b/%h/%b",
                         k, o.an, o.sseg, o.dp, e.an, e.sseg, e.dp);
            end
            n_run++;
            if ((k == 0 && c != 5) || (c - 5) % 4 != 0) begin
                n_fail++; $display("FAIL reset_timing%0d got edge %0d", k, c);
            end
        end
    endtask

    task automatic test_scan_dp();
        slot_t o, e;
        int c;
        bit ok;
        logic [15:0] vals[2] = '{16'h1234, 16'h89EF};
        logic [3:0]  dps[2]  = '{4'b0101, 4'b1010};
        for (int p = 0; p < 2; p++) begin
            value = vals[p];
            dp_in = dps[p];
            push_slots(4, value, dp_in);
            for (int k = 0; k < 4; k++) begin
                next_slot(o, c, ok);
                e = sb.pop_front();
                n_run++;
                if (!ok || o !== e) begin
                    n_fail++;
                    $display("FAIL scan_dp%0d_%0d got %b/%h/%b want %b/%h/%b",
                             p, k, o.an, o.sseg, o.dp, e.an, e.sseg, e.dp);
                end
                n_run++;
                if ((c - 5) % 4 != 0) begin
                    n_fail++; $display("FAIL scan_period%0d_%0d got edge %0d", p, k, c);
                end
            end
        end
    endtask

    task automatic test_short_pulse();
        bit seen;
        seen = 1'b0;
        but0 = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (frozen) seen = 1'b1;
        end
        but0 = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (frozen) seen = 1'b1;
        end
        n_run++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL short_pulse frozen went 1 want 0");
        end
    endtask

    task automatic test_freeze();
        slot_t o, e;
        int c;
        bit ok;
        value = 16'hABCD;
        dp_in = 4'b0011;
        but0  = 1'b1;
        repeat (20) @(negedge clk);
        n_run++;
        if (frozen !== 1'b1) begin
            n_fail++; $display("FAIL freeze_on got %b want 1", frozen);
        end
        value = 16'h0000;
        dp_in = 4'b0000;
        but0  = 1'b0;
        push_slots(4, 16'hABCD, 4'b0011);
        for (int k = 0; k < 4; k++) begin
            next_slot(o, c, ok);
            e = sb.pop_front();
            n_run++;
            if (!ok || o !== e) begin
                n_fail++;
                $display("FAIL freeze_hold%0d got %b/%h/%b want %b/%h/%b",
                         k, o.an, o.sseg, o.dp, e.an, e.sseg, e.dp);
            end
        end
        repeat (15) @(negedge clk);
        but0 = 1'b1;
        repeat (20) @(negedge clk);
        n_run++;
        if (frozen !== 1'b0) begin
            n_fail++; $display("FAIL freeze_off got %b want 0", frozen);
        end
        but0 = 1'b0;
        push_slots(4, value, dp_in);
        for (int k = 0; k < 4; k++) begin
            next_slot(o, c, ok);
            e = sb.pop_front();
            n_run++;
            if (!ok || o !== e) begin
                n_fail++;
                $display("FAIL freeze_live%0d got %b/%h/%b want %b/%h/%b",
                         k, o.an, o.sseg, o.dp, e.an, e.sseg, e.dp);
            end
        end
        repeat (15) @(negedge clk);
    endtask

    task automatic test_glitch();
        but0 = 1'b1;
        repeat (20) @(negedge clk);
        n_run++;
        if (frozen !== 1'b1) begin
            n_fail++; $display("FAIL glitch_press got %b want 1", frozen);
        end
        for (int i = 0; i < 10; i++) begin
            but0 = ~but0;
            repeat (3) @(negedge clk);
            n_run++;
            if (frozen !== 1'b1) begin
                n_fail++; $display("FAIL glitch%0d got %b want 1", i, frozen);
            end
        end
        repeat (10) @(negedge clk);
        but0 = 1'b0;
        repeat (15) @(negedge clk);
        n_run++;
        if (frozen !== 1'b1) begin
            n_fail++; $display("FAIL glitch_release got %b want 1", frozen);
        end
    endtask

    task automatic test_reset_mid();
        slot_t o, e;
        int c;
        bit ok;
        value = 16'h1234;
        dp_in = 4'b1000;
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_run++;
        if (an !== 4'hF || sseg !== 7'h7F || frozen !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got an=%b sseg=%h frozen=%b want 1111/7f/0",
                     an, sseg, frozen);
        end
        @(negedge clk);
        rst = 1'b0;
        push_slots(4, value, dp_in);
        for (int k = 0; k < 4; k++) begin
            next_slot(o, c, ok);
            e = sb.pop_front();
            n_run++;
            if (!ok || o !== e || (k == 0 && c != 5)) begin
                n_fail++;
                $display("FAIL reset_mid_scan%0d got %b/%h/%b@%0d want %b/%h/%b",
                         k, o.an, o.sseg, o.dp, c, e.an, e.sseg, e.dp);
            end
        end
    endtask

    task automatic test_lead_zero();
        slot_t o, e;
        int c;
        bit ok;
        logic [15:0] vals[2] = '{16'h0050, 16'h0000};
        for (int p = 0; p < 2; p++) begin
            value = vals[p];
            dp_in = 4'b0100;
            push_slots(4, value, dp_in);
            for (int k = 0; k < 4; k++) begin
                next_slot(o, c, ok);
                e = sb.pop_front();
                n_run++;
                if (!ok || o !== e) begin
                    n_fail++;
                    $display("FAIL lead%0d_%0d got %b/%h/%b want %b/%h/%b",
                             p, k, o.an, o.sseg, o.dp, e.an, e.sseg, e.dp);
                end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan_dp();
        test_short_pulse();
        test_freeze();
        test_glitch();
        test_reset_mid();
        test_lead_zero();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
